// File: rtl/mac_if.sv
// ----------------------------------------------------------------------------
// mac_if : matched-pair input and ready/valid result bundle of mac_accumulator
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mac_if #(
  parameter int VALUE_W = 8,
  parameter int ACC_W   = 32
);
  logic                           mac_valid_i;
  logic                           mac_finish_i;
  logic [1:0][VALUE_W-1:0]        mac_data_i;
  logic                           result_valid_o;
  logic                           result_ready_i;
  logic [ACC_W-1:0]               result_data_o;
  logic [15:0]                    result_count_o;
  logic                           result_overflow_o;
  logic                           protocol_err_o;

  modport slave (
    input  mac_valid_i, mac_finish_i, mac_data_i, result_ready_i,
    output result_valid_o, result_data_o, result_count_o,
           result_overflow_o, protocol_err_o
  );

  modport master (
    output mac_valid_i, mac_finish_i, mac_data_i, result_ready_i,
    input  result_valid_o, result_data_o, result_count_o,
           result_overflow_o, protocol_err_o
  );
endinterface

`default_nettype wire

// File: rtl/mac_accumulator.sv
// ----------------------------------------------------------------------------
// mac_accumulator : signed multiply-accumulate of matched pairs, result on ready/valid
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_accumulator #(
  parameter int VALUE_W  = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  wire logic mac_clk,
  input  wire logic mac_rst,
  mac_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_RESULT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                        r_state;
  state_t                        w_next_state;
  logic                          r_finish_q;
  logic signed [2*VALUE_W-1:0]   r_prod_q;
  logic                          r_prod_vld_q;
  logic        [ACC_W-1:0]       r_acc;
  logic        [15:0]            r_count;
  logic                          r_overflow;
  logic                          r_err;

  logic                          w_finish_edge;
  logic signed [VALUE_W-1:0]     w_a;
  logic signed [VALUE_W-1:0]     w_b;
  logic signed [2*VALUE_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]       w_prod_ext;
  logic        [ACC_W-1:0]       w_sum;
  logic                          w_ovf;
  logic        [ACC_W-1:0]       w_acc_next;
  logic                          w_result_valid;
  logic        [ACC_W-1:0]       w_result_data;
  logic        [15:0]            w_result_count;
  logic                          w_result_ovf;

  assign w_finish_edge = bus.mac_finish_i & ~r_finish_q;
  assign w_a           = bus.mac_data_i[0];
  assign w_b           = bus.mac_data_i[1];
  assign w_prod        = w_a * w_b;
  assign w_prod_ext    = ACC_W'(r_prod_q);
  assign w_sum         = r_acc + w_prod_ext;

  // Signed overflow: addends share a sign that the sum does not.
  assign w_ovf      = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_acc_next = (w_ovf && (SATURATE != 0)) ?
                      (r_acc[ACC_W-1] ? c_acc_min : c_acc_max) : w_sum;

  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      r_state      <= ST_ACCUM;
      r_finish_q   <= 1'b0;
      r_prod_q     <= '0;
      r_prod_vld_q <= 1'b0;
      r_acc        <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_finish_q   <= bus.mac_finish_i;
      r_prod_q     <= w_prod;
      r_prod_vld_q <= bus.mac_valid_i && (r_state == ST_ACCUM);

      if ((r_state == ST_WAIT_REL) && !bus.mac_finish_i) begin
        r_acc      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (r_prod_vld_q) begin
        r_acc      <= w_acc_next;
        r_overflow <= r_overflow | w_ovf;
        if (r_count != 16'hFFFF) begin
          r_count <= r_count + 16'd1;
        end
      end

      if (bus.mac_valid_i && (r_state != ST_ACCUM)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_result_valid = 1'b0;
    w_result_data  = '0;
    w_result_count = '0;
    w_result_ovf   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_finish_edge) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_next_state = ST_RESULT;
      end
      ST_RESULT: begin
        w_result_valid = 1'b1;
        w_result_data  = r_acc;
        w_result_count = r_count;
        w_result_ovf   = r_overflow;
        if (bus.result_ready_i) w_next_state = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!bus.mac_finish_i) w_next_state = ST_ACCUM;
      end
      default: w_next_state = ST_ACCUM;
    endcase
  end

  assign bus.result_valid_o    = w_result_valid;
  assign bus.result_data_o     = w_result_data;
  assign bus.result_count_o    = w_result_count;
  assign bus.result_overflow_o = w_result_ovf;
  assign bus.protocol_err_o    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ----------------------------------------------------------------------------
// tb_mac_accumulator : directed self-checking bench for mac_accumulator
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       t_valid;
  logic       t_finish;
  logic       t_ready;
  logic [7:0] t_a;
  logic [7:0] t_b;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  mac_if #(.VALUE_W(8), .ACC_W(32)) if32 ();
  mac_if #(.VALUE_W(8), .ACC_W(16)) if16s ();
  mac_if #(.VALUE_W(8), .ACC_W(16)) if16w ();

  assign if32.mac_valid_i     = t_valid;
  assign if32.mac_finish_i    = t_finish;
  assign if32.mac_data_i      = {t_b, t_a};
  assign if32.result_ready_i  = t_ready;
  assign if16s.mac_valid_i    = t_valid;
  assign if16s.mac_finish_i   = t_finish;
  assign if16s.mac_data_i     = {t_b, t_a};
  assign if16s.result_ready_i = t_ready;
  assign if16w.mac_valid_i    = t_valid;
  assign if16w.mac_finish_i   = t_finish;
  assign if16w.mac_data_i     = {t_b, t_a};
  assign if16w.result_ready_i = t_ready;

  mac_accumulator #(.VALUE_W(8), .ACC_W(32), .SATURATE(1)) u_dut32 (
    .mac_clk(clk), .mac_rst(rst), .bus(if32));
  mac_accumulator #(.VALUE_W(8), .ACC_W(16), .SATURATE(1)) u_dut16s (
    .mac_clk(clk), .mac_rst(rst), .bus(if16s));
  mac_accumulator #(.VALUE_W(8), .ACC_W(16), .SATURATE(0)) u_dut16w (
    .mac_clk(clk), .mac_rst(rst), .bus(if16w));

  task automatic check_value(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input int a, input int b);
    t_valid = 1'b1;
    t_a     = 8'(a);
    t_b     = 8'(b);
    tick();
    t_valid = 1'b0;
  endtask

  // Raise finish and confirm result_valid appears exactly two cycles later.
  task automatic finish_vector(input string tag);
    t_finish = 1'b1;
    tick();
    t_valid = 1'b0;
    check_value({tag, "_valid_early"}, longint'(if32.result_valid_o), 0);
    tick();
    check_value({tag, "_valid"}, longint'(if32.result_valid_o), 1);
  endtask

  task automatic check_result32(input string tag, input longint d, input longint c,
                                input longint o);
    check_value({tag, "_data"}, longint'($signed(if32.result_data_o)), d);
    check_value({tag, "_count"}, longint'(if32.result_count_o), c);
    check_value({tag, "_ovf"}, longint'(if32.result_overflow_o), o);
  endtask

  task automatic accept_and_release(input string tag);
    t_ready = 1'b1;
    tick();
    t_ready = 1'b0;
    check_value({tag, "_valid_drop"}, longint'(if32.result_valid_o), 0);
    t_finish = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; t_valid = 1'b0; t_finish = 1'b0; t_ready = 1'b0; t_a = '0; t_b = '0;
    tick();
    tick();
    check_value("rst_valid", longint'(if32.result_valid_o), 0);
    check_value("rst_data", longint'(if32.result_data_o), 0);
    check_value("rst_err", longint'(if32.protocol_err_o), 0);
    rst = 1'b0;
    tick();

    // Basic three-pair dot product
    send_pair(3, 4);
    send_pair(-2, 5);
    send_pair(7, 7);
    finish_vector("t1");
    check_result32("t1", 51, 3, 0);
    check_value("t1_data16s", longint'($signed(if16s.result_data_o)), 51);
    check_value("t1_data16w", longint'($signed(if16w.result_data_o)), 51);
    accept_and_release("t1");

    // Last pair shares its cycle with the finish edge; ready held high
    for (int i = 0; i < 4; i++) send_pair(127, 127);
    t_ready = 1'b1;
    t_valid = 1'b1; t_a = 8'h80; t_b = 8'h80;
    finish_vector("t2");
    check_result32("t2", 80900, 5, 0);
    accept_and_release("t2");

    // 16-bit accumulator overflow, saturating vs wrapping
    for (int i = 0; i < 3; i++) send_pair(127, 127);
    finish_vector("t3");
    check_result32("t3", 48387, 3, 0);
    check_value("t3_sat_data", longint'($signed(if16s.result_data_o)), 32767);
    check_value("t3_sat_ovf", longint'(if16s.result_overflow_o), 1);
    check_value("t3_wrap_data", longint'($signed(if16w.result_data_o)), -17149);
    check_value("t3_wrap_ovf", longint'(if16w.result_overflow_o), 1);
    accept_and_release("t3");

    // Backpressure hold, finish held after accept, then a fresh vector
    send_pair(5, -5);
    finish_vector("t4");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("t4_hold_valid", longint'(if32.result_valid_o), 1);
      check_result32("t4_hold", -25, 1, 0);
    end
    t_ready = 1'b1;
    tick();
    t_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_value("t4_no_second", longint'(if32.result_valid_o), 0);
    end
    t_finish = 1'b0;
    tick();
    send_pair(2, 3);
    finish_vector("t4b");
    check_result32("t4b", 6, 1, 0);
    accept_and_release("t4b");

    // Empty vector and a protocol violation while the result is presented
    check_value("t5_err_before", longint'(if32.protocol_err_o), 0);
    finish_vector("t5");
    check_result32("t5", 0, 0, 0);
    send_pair(9, 9);
    tick();
    check_value("t5_err", longint'(if32.protocol_err_o), 1);
    check_value("t5_still_valid", longint'(if32.result_valid_o), 1);
    check_result32("t5_after", 0, 0, 0);
    accept_and_release("t5");

    // Reset in the middle of a vector
    send_pair(10, 10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("t6_rst_valid", longint'(if32.result_valid_o), 0);
    check_result32("t6_rst", 0, 0, 0);
    check_value("t6_rst_err", longint'(if32.protocol_err_o), 0);
    send_pair(1, 1);
    finish_vector("t6");
    check_result32("t6", 1, 1, 0);
    accept_and_release("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
